mac_addr_seq: RTL and testbench
===============================

MAC_ADDR_SEQ -- requirements
Module: mac_addr_seq

Interface
REQ-001 Parameter NDIR, default 4: address width of the A/B operand memories.
REQ-002 Parameter NPAIR, default 4: complex operand pairs per dot product (row).
REQ-003 Parameter NROW, default 2: dot products (rows) per run.
REQ-004 Parameter TICK_DIV, default 4: clk cycles per sequencer step (slow tick), minimum 1.
REQ-005 Parameter PIPE_LAT, default 3: ticks between the last ena step and the point where the accumulator is valid.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  run request, sampled only in IDLE.
REQ-009 addr_a  out  NDIR  address of real/first operand word.
REQ-010 addr_b  out  NDIR  address of imag/second operand word.
REQ-011 ena  out  1  accumulate enable to the MAC datapath.
REQ-012 clr_acc  out  1  accumulator clear.
REQ-013 acc_vld  out  1  one-clk strobe: accumulator holds a finished row.
REQ-014 row_idx  out  clog2(NROW)+1  row index qualifying acc_vld.
REQ-015 tick  out  1  one-clk step strobe (slow-clock replacement).
REQ-016 busy  out  1  high from start acceptance until done.
REQ-017 done  out  1  one-clk strobe at end of run.

Function
REQ-018 FSM states IDLE, CLEAR, RUN, FLUSH, DONE; IDLE is the reset state.
REQ-019 IDLE: start=1 at edge E0 -> CLEAR, prescaler=0, row=0, k=0, busy=1.
REQ-020 Prescaler counts 0..TICK_DIV-1 while busy; tick=1 when count==TICK_DIV-1; TICK_DIV=1 -> tick every cycle.
REQ-021 CLEAR: clr_acc=1, ena=0; on tick -> RUN.
REQ-022 RUN: ena=1, addr_a=(row*2*NPAIR+2k) mod 2^NDIR, addr_b=addr_a+1 mod 2^NDIR; on tick k increments; on tick with k==NPAIR-1 -> FLUSH, k=0.
REQ-023 FLUSH: ena=0, addresses hold last value; after PIPE_LAT ticks, acc_vld=1 for one clk with row_idx=row; then row<NROW-1 -> CLEAR with row+1, else -> DONE.
REQ-024 DONE: done=1 for exactly one clk, busy=0 in that cycle, next state IDLE.
REQ-025 start while busy or in DONE is ignored; no queueing.
REQ-026 Run length from E0 to DONE entry is exactly (1+NPAIR+PIPE_LAT)*NROW*TICK_DIV clk.
REQ-027 Outputs are registered; no combinational path from start to any output.

Reset
REQ-028 rst=0 forces IDLE asynchronously: addr_a=0, addr_b=0, ena=0, clr_acc=0, acc_vld=0, row_idx=0, tick=0, busy=0, done=0, counters=0.
REQ-029 Reset mid-run discards progress; no done or acc_vld is issued for the aborted run.
REQ-030 After rst release, first start accepted on the first rising edge with start=1.

Configuration
REQ-031 Macro MAC_ADDR_SEQ_ABORT_EN defined: extra input abort (1 bit); abort=1 in any busy state -> IDLE on next edge, ena=0, clr_acc=0, busy=0, no done, no acc_vld; abort in IDLE has no effect.
REQ-032 Macro undefined: no abort port; behaviour as REQ-018..027.

Structure
REQ-033 Package mac_seq_pkg holds the state encoding constants and the default parameter values.
REQ-034 Prescaler is sub-module mac_tick_gen (inputs clk, rst, run; output tick); everything else in mac_addr_seq.

Verification (defaults)
REQ-035 start pulse at E0 -> clr_acc high E0..E0+3, ena rises at E0+4, addr pairs (0,1),(2,3),(4,5),(6,7) each held 4 clk.
REQ-036 Full run -> acc_vld at row_idx 0 then 1, row-1 pairs (8,9)..(14,15), done high exactly at E0+64 for one clk, busy falls with it.
REQ-037 start held high continuously -> new run begins only after IDLE re-entry, one clk after done.
REQ-038 rst asserted at E0+20 -> all outputs 0 within same cycle, no acc_vld or done, next start restarts at address 0.
REQ-039 TICK_DIV=1, NPAIR=8, NROW=1 -> addresses 0..15 stepped every clk, done at E0+12, addr_b wraps correctly.
REQ-040 With MAC_ADDR_SEQ_ABORT_EN, abort at E0+10 -> IDLE next edge, ena=0, done never asserted.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared constants for the MAC address sequencer.
// Holds the FSM state encoding, the default parameter values and a small
// helper that computes the first operand address of a row.
package mac_seq_pkg;

    // Default parameter values
    localparam int DEF_NDIR     = 4;
    localparam int DEF_NPAIR    = 4;
    localparam int DEF_NROW     = 2;
    localparam int DEF_TICK_DIV = 4;
    localparam int DEF_PIPE_LAT = 3;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Address of the first operand word of a row: each pair occupies two words.
    function automatic int row_base(input int row, input int npair);
        return row * 2 * npair;
    endfunction

endpackage

// File: rtl/mac_tick_gen.sv
// mac_tick_gen: step prescaler for the MAC sequencer.
// Counts 0..TICK_DIV-1 while run is high and flags the last count as tick.
// Held at zero while run is low so every run starts from a fresh step.
module mac_tick_gen
    import mac_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int              CW     = $clog2(TICK_DIV) + 1;
    localparam logic [CW-1:0]   C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler count, cleared whenever the sequencer is not running
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            cnt <= '0;
        end else if (!run || cnt == C_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == C_LAST);

endmodule

// File: rtl/mac_addr_seq.sv
// mac_addr_seq: address/control sequencer for a complex MAC datapath.
// Each row runs CLEAR (1 step), RUN (NPAIR steps, one operand pair per step)
// and FLUSH (PIPE_LAT steps), then moves to the next row or to DONE.
// A step lasts TICK_DIV clk cycles and is paced by mac_tick_gen.
// Build option: define MAC_ADDR_SEQ_ABORT_EN to add an abort input that
// drops a busy run back to IDLE without done or acc_vld.
module mac_addr_seq
    import mac_seq_pkg::*;
#(
    parameter int NDIR     = DEF_NDIR,
    parameter int NPAIR    = DEF_NPAIR,
    parameter int NROW     = DEF_NROW,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MAC_ADDR_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  start,
    output logic [NDIR-1:0]       addr_a,
    output logic [NDIR-1:0]       addr_b,
    output logic                  ena,
    output logic                  clr_acc,
    output logic                  acc_vld,
    output logic [$clog2(NROW):0] row_idx,
    output logic                  tick,
    output logic                  busy,
    output logic                  done
);

    localparam int            RW     = $clog2(NROW) + 1;
    localparam int            KW     = $clog2(NPAIR) + 1;
    localparam int            FW     = $clog2(PIPE_LAT) + 1;
    localparam logic [RW-1:0] R_LAST = RW'(NROW - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NPAIR - 1);
    localparam logic [FW-1:0] F_LAST = FW'(PIPE_LAT - 1);

    logic [2:0]    state;
    logic [RW-1:0] row;
    logic [KW-1:0] k;
    logic [FW-1:0] fcnt;
    logic          abort_req;

`ifdef MAC_ADDR_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Step pacing runs exactly while the sequencer is busy
    mac_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (busy),
        .tick (tick)
    );

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            row     <= '0;
            k       <= '0;
            fcnt    <= '0;
            addr_a  <= '0;
            addr_b  <= '0;
            ena     <= 1'b0;
            clr_acc <= 1'b0;
            acc_vld <= 1'b0;
            row_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Strobes are low unless a branch below raises them for one clk
            acc_vld <= 1'b0;
            done    <= 1'b0;
            if (abort_req && busy) begin
                state   <= ST_IDLE;
                row     <= '0;
                k       <= '0;
                fcnt    <= '0;
                ena     <= 1'b0;
                clr_acc <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_CLEAR;
                            row     <= '0;
                            k       <= '0;
                            fcnt    <= '0;
                            busy    <= 1'b1;
                            clr_acc <= 1'b1;
                            ena     <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        if (tick) begin
                            state   <= ST_RUN;
                            clr_acc <= 1'b0;
                            ena     <= 1'b1;
                            k       <= '0;
                            addr_a  <= NDIR'(row_base(int'(row), NPAIR));
                            addr_b  <= NDIR'(row_base(int'(row), NPAIR) + 1);
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            if (k == K_LAST) begin
                                state <= ST_FLUSH;
                                ena   <= 1'b0;
                                k     <= '0;
                                fcnt  <= '0;
                            end else begin
                                k      <= k + 1'b1;
                                addr_a <= addr_a + NDIR'(2);
                                addr_b <= addr_a + NDIR'(3);
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (tick) begin
                            if (fcnt == F_LAST) begin
                                fcnt    <= '0;
                                acc_vld <= 1'b1;
                                row_idx <= row;
                                if (row == R_LAST) begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state   <= ST_CLEAR;
                                    row     <= row + 1'b1;
                                    clr_acc <= 1'b1;
                                end
                            end else begin
                                fcnt <= fcnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_addr_seq.sv
// tb_mac_addr_seq: scoreboard bench for mac_addr_seq.
// dut0 uses the default parameters; dut1 uses TICK_DIV=1, NPAIR=8, NROW=1.
// Stimulus pushes the expected event stream (clear end, ena rise, pair steps,
// acc_vld, done) with the cycle each must appear; a negedge monitor pops and
// compares every event the DUTs present.
module tb_mac_addr_seq;

    typedef enum int {K_ACC, K_DONE, K_CLR, K_ENA, K_ADDR} kind_e;

    typedef struct {
        kind_e kind;
        int    cyc;
        int    a;
        int    b;
        int    row;
        int    bz;
    } ev_t;

    localparam int BIG = 32'h3fff_ffff;
    localparam int AMOD = 16;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
`ifdef MAC_ADDR_SEQ_ABORT_EN
    logic abort0, abort1;
`endif
    logic [3:0] addr_a0, addr_b0, addr_a1, addr_b1;
    logic       ena0, clr_acc0, acc_vld0, tick0, busy0, done0;
    logic       ena1, clr_acc1, acc_vld1, tick1, busy1, done1;
    logic [1:0] row_idx0;
    logic [0:0] row_idx1;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic ena_prev0 = 1'b0;
    logic ena_prev1 = 1'b0;
    ev_t  q0[$];
    ev_t  q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_addr_seq dut0 (
        .clk     (clk),
        .rst     (rst),
`ifdef MAC_ADDR_SEQ_ABORT_EN
        .abort   (abort0),
`endif
        .start   (start0),
        .addr_a  (addr_a0),
        .addr_b  (addr_b0),
        .ena     (ena0),
        .clr_acc (clr_acc0),
        .acc_vld (acc_vld0),
        .row_idx (row_idx0),
        .tick    (tick0),
        .busy    (busy0),
        .done    (done0)
    );

    mac_addr_seq #(
        .NDIR     (4),
        .NPAIR    (8),
        .NROW     (1),
        .TICK_DIV (1),
        .PIPE_LAT (3)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
`ifdef MAC_ADDR_SEQ_ABORT_EN
        .abort   (abort1),
`endif
        .start   (start1),
        .addr_a  (addr_a1),
        .addr_b  (addr_b1),
        .ena     (ena1),
        .clr_acc (clr_acc1),
        .acc_vld (acc_vld1),
        .row_idx (row_idx1),
        .tick    (tick1),
        .busy    (busy1),
        .done    (done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue one expected event unless it falls after the cut-off cycle
    task automatic add(input int id, input kind_e kind, input int c, input int a,
                       input int b, input int row, input int bz, input int cut);
        ev_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.row = row; e.bz = bz;
        if (c <= cut) begin
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
    endtask

    // Expected event stream of one run started at edge e0
    task automatic push_run(input int id, input int e0, input int td, input int np,
                            input int nr, input int pl, input int cut);
        int s, c0, a, b;
        s = 1 + np + pl;
        for (int r = 0; r < nr; r++) begin
            c0 = e0 + r * s * td;
            add(id, K_CLR, c0 + td - 1, 0, 0, 0, 1, cut);
            for (int kk = 0; kk < np; kk++) begin
                a = (r * 2 * np + 2 * kk) % AMOD;
                b = (a + 1) % AMOD;
                if (kk == 0) add(id, K_ENA, c0 + td, a, b, 0, 1, cut);
                add(id, K_ADDR, c0 + td * (1 + kk) + td - 1, a, b, 0, 1, cut);
            end
            add(id, K_ACC, c0 + s * td, 0, 0, r, (r < nr - 1) ? 1 : 0, cut);
        end
        add(id, K_DONE, e0 + s * nr * td, 0, 0, 0, 0, cut);
    endtask

    task automatic observe(input int id, input kind_e kind, input int a, input int b,
                           input int row, input logic bz);
        ev_t e;
        logic empty;
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        n_vec++;
        if (empty) begin
            n_err++;
            $display("FAIL dut%0d_unexpected_%s: got event at cycle %0d a=%0d b=%0d row=%0d, required none",
                     id, kind.name(), cyc, a, b, row);
        end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b ||
                e.row != row || e.bz != int'(bz)) begin
                n_err++;
                $display("FAIL dut%0d_%s: got %s@%0d a=%0d b=%0d row=%0d busy=%0d, required %s@%0d a=%0d b=%0d row=%0d busy=%0d",
                         id, e.kind.name(), kind.name(), cyc, a, b, row, bz,
                         e.kind.name(), e.cyc, e.a, e.b, e.row, e.bz);
            end
        end
    endtask

    // Monitor: sample both DUTs mid-cycle and match their events in order
    always @(negedge clk) begin
        if (acc_vld0)         observe(0, K_ACC, 0, 0, int'(row_idx0), busy0);
        if (done0)            observe(0, K_DONE, 0, 0, 0, busy0);
        if (clr_acc0 && tick0) observe(0, K_CLR, 0, 0, 0, busy0);
        if (ena0 && !ena_prev0) observe(0, K_ENA, int'(addr_a0), int'(addr_b0), 0, busy0);
        if (ena0 && tick0)    observe(0, K_ADDR, int'(addr_a0), int'(addr_b0), 0, busy0);
        ena_prev0 = ena0;
        if (acc_vld1)         observe(1, K_ACC, 0, 0, int'(row_idx1), busy1);
        if (done1)            observe(1, K_DONE, 0, 0, 0, busy1);
        if (clr_acc1 && tick1) observe(1, K_CLR, 0, 0, 0, busy1);
        if (ena1 && !ena_prev1) observe(1, K_ENA, int'(addr_a1), int'(addr_b1), 0, busy1);
        if (ena1 && tick1)    observe(1, K_ADDR, int'(addr_a1), int'(addr_b1), 0, busy1);
        ena_prev1 = ena1;
    end

    // Advance to the negedge of the given cycle
    task automatic goto(input int target);
        if (cyc > target) begin
            n_vec++;
            n_err++;
            $display("FAIL goto: at cycle %0d, required cycle %0d not in future", cyc, target);
        end
        for (int i = 0; i < 2000 && cyc < target; i++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
`ifdef MAC_ADDR_SEQ_ABORT_EN
        abort0 = 1'b0;
        abort1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        // Reset state of both instances
        check("reset_dut0", {addr_a0, addr_b0, ena0, clr_acc0, acc_vld0, row_idx0, tick0, busy0, done0}, 0);
        check("reset_dut1", {addr_a1, addr_b1, ena1, clr_acc1, acc_vld1, row_idx1, tick1, busy1, done1}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // A: single full run on default parameters
        start0 = 1'b1;
        e0 = cyc + 1;
        push_run(0, e0, 4, 4, 2, 3, BIG);
        @(negedge clk);
        start0 = 1'b0;
        check("A_clear_at_e0", {clr_acc0, ena0, busy0}, 3'b101);
        goto(e0 + 3);
        check("A_clear_last", {clr_acc0, ena0}, 2'b10);
        goto(e0 + 4);
        check("A_ena_rise", {ena0, clr_acc0, addr_a0, addr_b0}, {1'b1, 1'b0, 4'd0, 4'd1});
        goto(e0 + 19);
        check("A_pair3", {ena0, addr_a0, addr_b0}, {1'b1, 4'd6, 4'd7});
        goto(e0 + 20);
        check("A_flush_hold", {ena0, addr_a0, addr_b0}, {1'b0, 4'd6, 4'd7});
        goto(e0 + 40);
        check("A_row1_pair1", {ena0, addr_a0, addr_b0}, {1'b1, 4'd10, 4'd11});
        goto(e0 + 63);
        check("A_before_done", {busy0, done0}, 2'b10);
        goto(e0 + 64);
        check("A_done", {done0, busy0, acc_vld0, row_idx0}, {1'b1, 1'b0, 1'b1, 2'd1});
        goto(e0 + 65);
        check("A_after_done", {done0, busy0, acc_vld0}, 3'b000);
        goto(e0 + 70);

        // B: start held high; next run only after IDLE re-entry
        start0 = 1'b1;
        e0 = cyc + 1;
        push_run(0, e0, 4, 4, 2, 3, BIG);
        push_run(0, e0 + 66, 4, 4, 2, 3, BIG);
        goto(e0 + 65);
        check("B_idle_gap", {busy0, done0, clr_acc0}, 3'b000);
        goto(e0 + 66);
        start0 = 1'b0;
        check("B_restart", {busy0, clr_acc0}, 2'b11);
        goto(e0 + 66 + 70);

        // C: reset mid-run discards the run, then restart from address 0
        start0 = 1'b1;
        e0 = cyc + 1;
        push_run(0, e0, 4, 4, 2, 3, e0 + 20);
        @(negedge clk);
        start0 = 1'b0;
        goto(e0 + 20);
        #2;
        rst = 1'b0;
        #1;
        check("C_reset_outputs", {addr_a0, addr_b0, ena0, clr_acc0, acc_vld0, row_idx0, tick0, busy0, done0}, 0);
        goto(e0 + 23);
        rst = 1'b1;
        goto(e0 + 80);
        start0 = 1'b1;
        e0 = cyc + 1;
        push_run(0, e0, 4, 4, 2, 3, BIG);
        @(negedge clk);
        start0 = 1'b0;
        goto(e0 + 4);
        check("C_restart_addr", {ena0, addr_a0, addr_b0}, {1'b1, 4'd0, 4'd1});
        goto(e0 + 70);

        // D: fast variant, a new pair every clk, done after 12 clk
        start1 = 1'b1;
        e0 = cyc + 1;
        push_run(1, e0, 1, 8, 1, 3, BIG);
        @(negedge clk);
        start1 = 1'b0;
        check("D_clear_at_e0", {clr_acc1, tick1, busy1}, 3'b111);
        goto(e0 + 8);
        check("D_last_pair", {ena1, addr_a1, addr_b1}, {1'b1, 4'd14, 4'd15});
        goto(e0 + 12);
        check("D_done", {done1, busy1, acc_vld1}, 3'b101);
        goto(e0 + 13);
        check("D_after_done", {done1, busy1}, 2'b00);
        goto(e0 + 20);

`ifdef MAC_ADDR_SEQ_ABORT_EN
        // E: abort mid-run returns to IDLE with no done
        start0 = 1'b1;
        e0 = cyc + 1;
        push_run(0, e0, 4, 4, 2, 3, e0 + 10);
        @(negedge clk);
        start0 = 1'b0;
        goto(e0 + 10);
        abort0 = 1'b1;
        goto(e0 + 11);
        abort0 = 1'b0;
        check("E_abort_idle", {ena0, clr_acc0, busy0, done0, acc_vld0}, 5'b00000);
        goto(e0 + 80);
`endif

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
